jtag_host: RTL and testbench

- Host-side JTAG sequencer. It is the initiator end of the TAP protocol and drives tms/tdi into a device TAP while sampling its tdo.
- It accepts one command at a time: TAP reset, IR scan, DR scan, or run-test idle clocks. For each it emits the exact 1149.1 TMS/TDI sequence and returns the shifted-out bits.
- It runs on the same tck as the TAP it drives and is used in simulation benches and on-chip self-test of the debug TAP chain.

---
 rtl/jtag_host.sv | 163 ++++++++++++++++
 tb/tb_jtag_host.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host.sv
// Host-side JTAG sequencer: turns RESET / IR / DR / RUNTEST commands into 1149.1
// TMS/TDI sequences on tck and returns the TDO bits shifted out of the target TAP.
module jtag_host #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN)
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  // One extra bit so a full MAX_LEN shift terminates without wrapping.
  localparam int unsigned CNT_W = LEN_W + 1;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_RUN   = 2'd3;

  typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, DONE} state_e;

  state_e             state;
  logic [1:0]         op_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   cnt;
  logic [MAX_LEN-1:0] sreg;
  logic [MAX_LEN-1:0] cap;
  logic               accept;

  assign accept = cmd_valid && cmd_ready;

  // TMS for preamble cycle c; RUNTEST reuses the preamble as its idle run.
  function automatic logic pre_tms(input logic [1:0] op, input logic [CNT_W-1:0] c);
    logic r;
    case (op)
      OP_RESET: r = (c < CNT_W'(5));
      OP_IR:    r = (c < CNT_W'(2));
      OP_DR:    r = (c == '0);
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic pre_last(input logic [1:0] op, input logic [CNT_W-1:0] c,
                                    input logic [CNT_W-1:0] len);
    logic r;
    case (op)
      OP_RESET: r = (c == CNT_W'(5));
      OP_IR:    r = (c == CNT_W'(3));
      OP_DR:    r = (c == CNT_W'(2));
      default:  r = (c == len);
    endcase
    return r;
  endfunction

  always_ff @(posedge tck) begin
    if (trst) begin
      state     <= INIT;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      op_q      <= OP_RESET;
      len_q     <= '0;
      cnt       <= '0;
      sreg      <= '0;
      cap       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        op_q      <= cmd_op;
        len_q     <= CNT_W'(cmd_len);
        sreg      <= cmd_data;
        cap       <= '0;
        cnt       <= '0;
        tms       <= pre_tms(cmd_op, '0);
        tdi       <= 1'b0;
        cmd_ready <= 1'b0;
        state     <= PRE;
      end else begin
        case (state)
          INIT: begin
            if (cnt == '0) begin
              tms <= 1'b0;
              cnt <= CNT_W'(1);
            end else begin
              cnt       <= '0;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end
          IDLE: begin
            tms <= 1'b0;
            tdi <= 1'b0;
          end
          PRE: begin
            if (pre_last(op_q, cnt, len_q)) begin
              cnt <= '0;
              if (op_q == OP_IR || op_q == OP_DR) begin
                state <= SHIFT;
                tdi   <= sreg[0];
                sreg  <= sreg >> 1;
                tms   <= (len_q == '0);
              end else begin
                state     <= DONE;
                tms       <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                cmd_ready <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
              tms <= pre_tms(op_q, cnt + CNT_W'(1));
            end
          end
          SHIFT: begin
            cap[cnt[LEN_W-1:0]] <= tdo;
            if (cnt == len_q) begin
              state <= POST;
              cnt   <= '0;
              tms   <= 1'b1;
              tdi   <= 1'b0;
            end else begin
              cnt  <= cnt + CNT_W'(1);
              tdi  <= sreg[0];
              sreg <= sreg >> 1;
              tms  <= (cnt + CNT_W'(1) == len_q);
            end
          end
          POST: begin
            if (cnt == '0) begin
              cnt <= CNT_W'(1);
              tms <= 1'b0;
            end else begin
              state     <= DONE;
              cnt       <= '0;
              rsp_valid <= 1'b1;
              rsp_data  <= cap;
              cmd_ready <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            tms   <= 1'b0;
            tdi   <= 1'b0;
          end
          default: state <= INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Directed bench for jtag_host driving a small behavioural TAP (8-bit IR, IDCODE, BYPASS).
module tb_jtag_host;

  localparam logic [7:0]  IR_IDCODE = 8'h02;
  localparam logic [31:0] IDCODE    = 32'h4BA0_0477;

  logic        tck = 1'b0;
  logic        trst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [63:0] cmd_data = 64'd0;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        tms, tdi, tdo;

  int n_chk = 0;
  int n_err = 0;

  jtag_host dut (
    .tck(tck), .trst(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 tck = ~tck;

  // Target TAP model
  typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                            SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_e;
  tap_e        st;
  logic [7:0]  ir, ir_sr;
  logic [31:0] dr_sr;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    if (trst) begin
      st <= TLR;
      ir <= IR_IDCODE;
    end else begin
      st <= tap_next(st, tms);
      case (st)
        TLR:  ir <= IR_IDCODE;
        CIR:  ir_sr <= 8'h01;
        SHIR: ir_sr <= {tdi, ir_sr[7:1]};
        UIR:  ir <= ir_sr;
        CDR:  dr_sr <= (ir == IR_IDCODE) ? IDCODE : 32'h0;
        SHDR: dr_sr <= (ir == IR_IDCODE) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
        default: ;
      endcase
    end
  end

  assign tdo = (st == SHIR) ? ir_sr[0] : (st == SHDR) ? dr_sr[0] : 1'b0;

  task automatic step();
    @(posedge tck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold trst for 'hold' edges, release, and check the INIT handshake.
  task automatic reset_seq(input int hold);
    trst = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("rst_tms", 128'(tms), 128'd1);
      chk("rst_rv", 128'(rsp_valid), 128'd0);
      chk("rst_rdy", 128'(cmd_ready), 128'd0);
    end
    chk("rst_data", 128'(rsp_data), 128'd0);
    chk("rst_tdi", 128'(tdi), 128'd0);
    trst = 1'b0;
    step();
    chk("init_tms", 128'(tms), 128'd0);
    chk("init_rdy", 128'(cmd_ready), 128'd0);
    step();
    chk("idle_rdy", 128'(cmd_ready), 128'd1);
    chk("idle_tms", 128'(tms), 128'd0);
    chk("idle_rv", 128'(rsp_valid), 128'd0);
  endtask

  // Wait (bounded) for cmd_ready, present a command, return in cycle 0.
  task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [63:0] data,
                       input bit keep);
    for (int i = 0; i < 200 && !cmd_ready; i++) step();
    chk("ready_wait", 128'(cmd_ready), 128'd1);
    cmd_op = op;
    cmd_len = len;
    cmd_data = data;
    cmd_valid = 1'b1;
    step();
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Record outputs for cycles 0..ncyc-1; returns in cycle ncyc-1.
  task automatic watch(input int ncyc, input bit jitter,
                       output logic [127:0] tms_v, output logic [127:0] tdi_v,
                       output logic [127:0] rv_v, output logic [127:0] rdy_v,
                       output logic [63:0] rd);
    tms_v = '0; tdi_v = '0; rv_v = '0; rdy_v = '0; rd = '0;
    for (int c = 0; c < ncyc; c++) begin
      tms_v[c] = tms;
      tdi_v[c] = tdi;
      rv_v[c]  = rsp_valid;
      rdy_v[c] = cmd_ready;
      if (rsp_valid) rd = rsp_data;
      if (jitter) cmd_data = {$urandom, $urandom};
      if (c < ncyc - 1) step();
    end
  endtask

  logic [127:0] tv, dv, rv, yv;
  logic [63:0]  rd;

  initial begin
    // 1: reset release
    #1;
    reset_seq(3);

    // 2: IR scan of 0x05 (unknown opcode -> BYPASS)
    issue(2'd1, 6'd7, 64'h05, 1'b0);
    watch(15, 1'b0, tv, dv, rv, yv, rd);
    chk("ir_tms", tv, 128'h1803);
    chk("ir_tdi", dv, 128'h0050);
    chk("ir_rv", rv, 128'h4000);
    chk("ir_rdy", yv, 128'h4000);
    chk("ir_data", 128'(rd), 128'h01);

    // 3: 64-bit DR scan through BYPASS
    issue(2'd2, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    watch(70, 1'b0, tv, dv, rv, yv, rd);
    chk("dr64_tms", tv, (128'h1 << 67) | (128'h1 << 66) | 128'h1);
    chk("dr64_tdi", dv, 128'hFFFF_FFFF_FFFF_FFFF << 3);
    chk("dr64_rv", rv, 128'h1 << 69);
    chk("dr64_data", 128'(rd), 128'hFFFF_FFFF_FFFF_FFFE);

    // 4: RESET then back-to-back RUNTEST len=2
    issue(2'd0, 6'd0, 64'h0, 1'b1);
    cmd_op = 2'd3;
    cmd_len = 6'd2;
    watch(7, 1'b0, tv, dv, rv, yv, rd);
    chk("rst_op_tms", tv, 128'h1F);
    chk("rst_op_rv", rv, 128'h40);
    chk("rst_op_data", 128'(rd), 128'h0);
    step();
    cmd_valid = 1'b0;
    watch(4, 1'b0, tv, dv, rv, yv, rd);
    chk("run_tms", tv, 128'h0);
    chk("run_rv", rv, 128'h8);
    chk("run_rdy", yv, 128'h8);
    chk("run_data", 128'(rsp_data), 128'h0);

    // 6: busy DR scan with cmd_valid held and data changing
    issue(2'd1, 6'd7, 64'hFF, 1'b0);
    watch(15, 1'b0, tv, dv, rv, yv, rd);
    chk("ir_byp_data", 128'(rd), 128'h01);
    issue(2'd2, 6'd7, 64'hA5, 1'b1);
    watch(14, 1'b1, tv, dv, rv, yv, rd);
    chk("busy_tms", tv, 128'hC01);
    chk("busy_tdi", dv, 128'h528);
    chk("busy_rv", rv, 128'h2000);
    chk("busy_rdy", yv, 128'h2000);
    chk("busy_data", 128'(rd), 128'h4A);
    cmd_op = 2'd3;
    cmd_len = 6'd0;
    step();
    cmd_valid = 1'b0;
    chk("queued_acc", 128'(cmd_ready), 128'd0);
    watch(2, 1'b0, tv, dv, rv, yv, rd);
    chk("queued_rv", rv, 128'h2);

    // 5: abort a DR scan with trst, then read IDCODE
    issue(2'd2, 6'd31, 64'h0, 1'b0);
    watch(11, 1'b0, tv, dv, rv, yv, rd);
    chk("abort_pre_rv", rv, 128'h0);
    reset_seq(6);
    issue(2'd2, 6'd31, 64'h0, 1'b0);
    watch(38, 1'b0, tv, dv, rv, yv, rd);
    chk("idcode_rv", rv, 128'h1 << 37);
    chk("idcode_data", 128'(rd), 128'h4BA0_0477);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
